instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 28 ++
 rtl/instruction_fetch_if.sv | 30 +++
 rtl/instruction_fetch_if_id_reg.sv | 46 ++++
 rtl/instruction_fetch.sv | 123 ++++++++++++
 tb/tb_instruction_fetch.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg
// Shared types and constants for the instruction fetch slice.
//   fetch_state_e     : fetch FSM state encoding (RUN / DRAIN / HALTED)
//   *_DEF             : default parameter values for instruction_fetch
//   BUBBLE_IR/_VALID  : encoding of an empty IF/ID slot
//   jump_target()     : J-type target formation from PC+4 and the 26-bit index
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF     = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEF    = 32'hFFFF_FFFF;
  localparam int unsigned DRAIN_CYCLES_DEF = 4;

  localparam logic [31:0] BUBBLE_IR    = 32'h0000_0000;
  localparam logic        BUBBLE_VALID = 1'b0;

  // Upper nibble comes from the PC+4 of the jump itself, not the current PC.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                               input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if
// Groups the fetch unit's memory, hazard, redirect and IF/ID signals.
//   slave  : the fetch unit (drives pc_address, IF/ID outputs, halted)
//   master : the surrounding pipeline / memory (drives ir, stall, redirects)
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic [31:0] pc_address;
  logic [31:0] ir;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;

  modport slave (
    input  ir, stall, branch_taken, branch_target, jump, jump_index,
    output pc_address, if_id_ir, if_id_pc4, if_id_valid, halted
  );

  modport master (
    output ir, stall, branch_taken, branch_target, jump, jump_index,
    input  pc_address, if_id_ir, if_id_pc4, if_id_valid, halted
  );

endinterface

// File: rtl/instruction_fetch_if_id_reg.sv
// if_id_reg
// IF/ID pipeline register.
//   clk_i, rst_i : clock, synchronous active-high reset (clears to bubble)
//   load_i       : capture ir_i / pc4_i as a valid instruction
//   flush_i      : insert a bubble (wins over load_i)
//   neither      : hold
//   ir_o, pc4_o, valid_o : registered instruction, its PC+4, valid flag
module if_id_reg
  import instruction_fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] ir_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] ir_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  // A bubble only clears ir/valid; pc4 keeps its last value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      ir_q    <= BUBBLE_IR;
      valid_q <= BUBBLE_VALID;
    end else if (load_i) begin
      ir_q    <= ir_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign ir_o    = ir_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
// PC register, next-PC selection and halt/drain state machine.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : pc_address out, ir in, stall/branch/jump in,
//                  IF/ID outputs, halted out
// Parameters: RESET_PC, HALT_WORD, DRAIN_CYCLES (>= 1).
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_RUN    | normal fetch; redirects, stalls, halt-word detection
// ST_DRAIN  | halt seen; PC held, bubbles issued while counter runs
// ST_HALTED | terminal until reset; everything frozen, halted = 1
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter logic [31:0] HALT_WORD    = HALT_WORD_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  instruction_fetch_if.slave bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;

  logic             load, flush;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [31:0]      pc_plus4;
  logic [31:0]      if_ir, if_pc4;
  logic             if_valid;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = bus.branch_taken | bus.jump;
  // Branch beats jump; branch target is forced word-aligned.
  assign redirect_pc = bus.branch_taken ? {bus.branch_target[31:2], 2'b00}
                                        : jump_target(if_pc4, bus.jump_index);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          pc_d  = redirect_pc;
          flush = 1'b1;
        end else if (bus.stall) begin
          // hold PC and IF/ID
        end else if (bus.ir == HALT_WORD) begin
          flush   = 1'b1;
          state_d = ST_DRAIN;
          cnt_d   = CNT_LOAD;
        end else begin
          pc_d = pc_plus4;
          load = 1'b1;
        end
      end
      ST_DRAIN: begin
        flush = 1'b1;
        if (redirect) begin
          // halt was fetched down a wrong path
          pc_d    = redirect_pc;
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HALTED: begin
        // frozen until reset
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load),
    .flush_i (flush),
    .ir_i    (bus.ir),
    .pc4_i   (pc_plus4),
    .ir_o    (if_ir),
    .pc4_o   (if_pc4),
    .valid_o (if_valid)
  );

  assign bus.pc_address  = pc_q;
  assign bus.if_id_ir    = if_ir;
  assign bus.if_id_pc4   = if_pc4;
  assign bus.if_id_valid = if_valid;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
// Directed bench for instruction_fetch with a combinational instruction
// memory: word at address a is {8'hC0, a[23:0]}, except halt_addr which
// returns the halt word.
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] halt_addr;
  int          n_cmp = 0;
  int          n_bad = 0;

  instruction_fetch_if ifc ();

  instruction_fetch #(
    .RESET_PC     (32'h0000_0000),
    .HALT_WORD    (HALT),
    .DRAIN_CYCLES (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  assign ifc.ir = (ifc.pc_address == halt_addr) ? HALT
                                                : {8'hC0, ifc.pc_address[23:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc,
                          input logic [31:0] ir, input logic [31:0] pc4);
    chk({tag, ".pc"},    ifc.pc_address,  pc);
    chk({tag, ".ir"},    ifc.if_id_ir,    ir);
    chk({tag, ".pc4"},   ifc.if_id_pc4,   pc4);
    chk({tag, ".valid"}, 32'(ifc.if_id_valid), 32'd1);
  endtask

  task automatic chk_bubble(input string tag, input logic [31:0] pc, input logic halted);
    chk({tag, ".pc"},     ifc.pc_address, pc);
    chk({tag, ".ir"},     ifc.if_id_ir,   32'h0);
    chk({tag, ".valid"},  32'(ifc.if_id_valid), 32'd0);
    chk({tag, ".halted"}, 32'(ifc.halted),      32'(halted));
  endtask

  task automatic clear_inputs();
    ifc.stall         = 1'b0;
    ifc.branch_taken  = 1'b0;
    ifc.branch_target = 32'h0;
    ifc.jump          = 1'b0;
    ifc.jump_index    = 26'h0;
  endtask

  task automatic branch_to(input logic [31:0] tgt);
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = tgt;
    tick();
    clear_inputs();
  endtask

  initial begin
    rst       = 1'b1;
    halt_addr = 32'hDEAD_BEE0;
    clear_inputs();
    tick();
    tick();
    chk("rst.pc",     ifc.pc_address, 32'h0);
    chk("rst.ir",     ifc.if_id_ir,   32'h0);
    chk("rst.pc4",    ifc.if_id_pc4,  32'h0);
    chk("rst.valid",  32'(ifc.if_id_valid), 32'd0);
    chk("rst.halted", 32'(ifc.halted),      32'd0);

    // sequential fetch A, B
    rst = 1'b0;
    tick(); chk_ifid("seqA", 32'h4, 32'hC000_0000, 32'h4);
    tick(); chk_ifid("seqB", 32'h8, 32'hC000_0004, 32'h8);

    // stall two cycles at PC 8
    ifc.stall = 1'b1;
    tick(); chk_ifid("stall1", 32'h8, 32'hC000_0004, 32'h8);
    tick(); chk_ifid("stall2", 32'h8, 32'hC000_0004, 32'h8);
    ifc.stall = 1'b0;
    tick(); chk_ifid("seqC", 32'hC,  32'hC000_0008, 32'hC);
    tick(); chk_ifid("seqD", 32'h10, 32'hC000_000C, 32'h10);

    // branch with stall in same cycle, unaligned target
    ifc.stall = 1'b1;
    branch_to(32'h0000_0043);
    chk_bubble("br", 32'h40, 1'b0);
    tick(); chk_ifid("br.next", 32'h44, 32'hC000_0040, 32'h44);

    // jump using IF/ID pc4 = 0x1000_0008
    branch_to(32'h1000_0004);
    tick(); chk_ifid("jpre", 32'h1000_0008, 32'hC000_0004, 32'h1000_0008);
    ifc.jump       = 1'b1;
    ifc.jump_index = 26'h10;
    tick();
    clear_inputs();
    chk_bubble("jump", 32'h1000_0040, 1'b0);

    // PC wrap at top of address space
    branch_to(32'hFFFF_FFFC);
    tick(); chk_ifid("wrap", 32'h0, 32'hC0FF_FFFC, 32'h0);

    // halt at 0x20, stall asserted through drain must not pause it
    halt_addr = 32'h20;
    branch_to(32'h20);
    tick(); chk_bubble("halt.det", 32'h20, 1'b0);
    ifc.stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(); chk_bubble($sformatf("drain%0d", i), 32'h20, 1'b0);
    end
    tick(); chk_bubble("halted", 32'h20, 1'b1);
    // inputs ignored while halted
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = 32'h100;
    ifc.jump          = 1'b1;
    tick(); chk_bubble("halted.ign1", 32'h20, 1'b1);
    tick(); chk_bubble("halted.ign2", 32'h20, 1'b1);
    clear_inputs();

    // reset out of HALTED
    rst = 1'b1;
    tick();
    chk("rstH.pc",     ifc.pc_address, 32'h0);
    chk("rstH.halted", 32'(ifc.halted), 32'd0);
    chk("rstH.valid",  32'(ifc.if_id_valid), 32'd0);
    rst = 1'b0;
    tick(); chk_ifid("rstH.fetch", 32'h4, 32'hC000_0000, 32'h4);

    // halt cancelled by branch in 2nd drain cycle
    branch_to(32'h20);
    tick(); chk_bubble("cx.det", 32'h20, 1'b0);
    tick(); chk_bubble("cx.d1",  32'h20, 1'b0);
    branch_to(32'h80);
    chk_bubble("cx.redir", 32'h80, 1'b0);
    tick(); chk_ifid("cx.run", 32'h84, 32'hC000_0080, 32'h84);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("cx.nohalt%0d", i), 32'(ifc.halted), 32'd0);
    end
    chk("cx.pc", ifc.pc_address, 32'h94);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
